bsg_ss_tx_credit_channel: RTL and testbench



---
 rtl/bsg_ss_tx_credit_channel.sv | 71 +++++++
 tb/tb_bsg_ss_tx_credit_channel.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_ss_tx_credit_channel.sv
// Transmit side of a source-synchronous channel: registers producer words onto the pins,
// gated by a credit counter that is refilled by edges on the returned token.
module bsg_ss_tx_credit_channel #(
  parameter int width_p         = 8,
  parameter int credits_p       = 16,
  parameter int lg_decimation_p = 0,
  parameter int both_edges_p    = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic [width_p-1:0]             data_i,
  input  logic                           cmd_i,
  output logic                           ready_o,
  input  logic                           token_i,
  output logic [width_p-1:0]             data_o,
  output logic                           ncmd_o,
  output logic                           valid_o,
  output logic [$clog2(credits_p+1)-1:0] credits_o,
  output logic                           overflow_o
);

  localparam int cw_lp = $clog2(credits_p+1);
  // One extra bit so count + return never wraps before the saturation test.
  localparam logic [cw_lp:0] credits_lp = (cw_lp+1)'(credits_p);
  localparam logic [cw_lp:0] ret_amt_lp = (cw_lp+1)'(1 << lg_decimation_p);

  logic             tok_r;
  logic             rise;
  logic             fall;
  logic             ret;
  logic             send;
  logic [cw_lp:0]   sum;
  logic [cw_lp-1:0] credits_next;
  logic             overflow_next;

  assign ready_o = (credits_o != '0);
  assign send    = v_i & ready_o;
  assign rise    = token_i & ~tok_r;
  assign fall    = ~token_i & tok_r;
  assign ret     = (both_edges_p != 0) ? (rise | fall) : rise;

  always_comb begin
    sum           = {1'b0, credits_o} + (ret ? ret_amt_lp : '0) - (send ? (cw_lp+1)'(1) : '0);
    credits_next  = sum[cw_lp-1:0];
    overflow_next = overflow_o;
    if (sum > credits_lp) begin
      credits_next  = credits_lp[cw_lp-1:0];
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tok_r      <= 1'b0;
      credits_o  <= credits_lp[cw_lp-1:0];
      overflow_o <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      ncmd_o     <= 1'b1;
    end else begin
      tok_r      <= token_i;
      credits_o  <= credits_next;
      overflow_o <= overflow_next;
      valid_o    <= send;
      data_o     <= send ? data_i : '0;
      ncmd_o     <= ~(send & cmd_i);
    end
  end

endmodule

// File: tb/tb_bsg_ss_tx_credit_channel.sv
// Bench: three channel configurations (8 credits; decimation 1, 4 rising-only, 4 both edges)
// share one stimulus stream and are compared against a per-instance credit model.
module tb_bsg_ss_tx_credit_channel;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       v_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       cmd_i = 1'b0;
  logic       token_i = 1'b0;

  logic       ready[3];
  logic [7:0] dout[3];
  logic       ncmd[3];
  logic       val[3];
  logic [3:0] cred[3];
  logic       ovf[3];

  always #5 clk = ~clk;

  bsg_ss_tx_credit_channel #(.width_p(8), .credits_p(8), .lg_decimation_p(0), .both_edges_p(0)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .cmd_i(cmd_i), .ready_o(ready[0]),
    .token_i(token_i), .data_o(dout[0]), .ncmd_o(ncmd[0]), .valid_o(val[0]), .credits_o(cred[0]),
    .overflow_o(ovf[0]));
  bsg_ss_tx_credit_channel #(.width_p(8), .credits_p(8), .lg_decimation_p(2), .both_edges_p(0)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .cmd_i(cmd_i), .ready_o(ready[1]),
    .token_i(token_i), .data_o(dout[1]), .ncmd_o(ncmd[1]), .valid_o(val[1]), .credits_o(cred[1]),
    .overflow_o(ovf[1]));
  bsg_ss_tx_credit_channel #(.width_p(8), .credits_p(8), .lg_decimation_p(2), .both_edges_p(1)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .cmd_i(cmd_i), .ready_o(ready[2]),
    .token_i(token_i), .data_o(dout[2]), .ncmd_o(ncmd[2]), .valid_o(val[2]), .credits_o(cred[2]),
    .overflow_o(ovf[2]));

  localparam int CAP = 8;
  int ret_amt[3] = '{1, 4, 4};
  bit both_mode[3] = '{1'b0, 1'b0, 1'b1};

  int total = 0;
  int bad = 0;

  // Reference: plain credit bookkeeping plus the expected pin values after the next edge.
  int m_cred[3];
  bit m_ovf[3];
  int m_dat[3];
  bit m_ncmd[3];
  bit m_val[3];
  bit m_tok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cred[k] = CAP;
      m_ovf[k]  = 1'b0;
      m_dat[k]  = 0;
      m_ncmd[k] = 1'b1;
      m_val[k]  = 1'b0;
    end
    m_tok = 1'b0;
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_data", k), 32'(dout[k]), 32'(m_dat[k]));
      chk($sformatf("d%0d_ncmd", k), 32'(ncmd[k]), 32'(m_ncmd[k]));
      chk($sformatf("d%0d_valid", k), 32'(val[k]), 32'(m_val[k]));
      chk($sformatf("d%0d_credits", k), 32'(cred[k]), 32'(m_cred[k]));
      chk($sformatf("d%0d_overflow", k), 32'(ovf[k]), 32'(m_ovf[k]));
      chk($sformatf("d%0d_ready", k), 32'(ready[k]), 32'(m_cred[k] != 0));
    end
  endtask

  task automatic model_update();
    bit rise, fall, send, ret;
    int n;
    rise = token_i && !m_tok;
    fall = !token_i && m_tok;
    for (int k = 0; k < 3; k++) begin
      send = v_i && (m_cred[k] > 0);
      ret  = rise || (both_mode[k] && fall);
      m_val[k]  = send;
      m_dat[k]  = send ? int'(data_i) : 0;
      m_ncmd[k] = send ? !cmd_i : 1'b1;
      n = m_cred[k] + (ret ? ret_amt[k] : 0) - (send ? 1 : 0);
      if (n > CAP) begin
        n = CAP;
        m_ovf[k] = 1'b1;
      end
      m_cred[k] = n;
    end
    m_tok = token_i;
  endtask

  // Called at a falling edge: check current pins, drive one cycle of inputs, advance.
  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic t);
    check_all();
    v_i = v;
    data_i = d;
    cmd_i = c;
    token_i = t;
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    chk("rst_credits", 32'(cred[0]), 32'd8);
    chk("rst_valid", 32'(val[0]), 32'd0);
    chk("rst_ncmd", 32'(ncmd[0]), 32'd1);
    chk("rst_overflow", 32'(ovf[0]), 32'd0);

    // Drain all credits with data 1..8, then one more attempt that must be refused.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("drain_last_data", 32'(dout[0]), 32'd8);
    step(1'b1, 8'h09, 1'b0, 1'b0);
    chk("drain_credits", 32'(cred[0]), 32'd0);
    chk("drain_ready", 32'(ready[0]), 32'd0);
    chk("drain_valid", 32'(val[0]), 32'd0);
    chk("drain_ncmd", 32'(ncmd[0]), 32'd1);

    // Decimated refill: rise gives 4; the fall counts only in both-edge mode.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dec_rise_d1", 32'(cred[1]), 32'd4);
    chk("dec_rise_d2", 32'(cred[2]), 32'd4);
    chk("dec_rise_d0", 32'(cred[0]), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("dec_fall_d1", 32'(cred[1]), 32'd4);
    chk("dec_fall_d2", 32'(cred[2]), 32'd8);

    // Command encoding on the both-edge instance.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("cmd_data", 32'(dout[2]), 32'hA5);
    chk("cmd_ncmd", 32'(ncmd[2]), 32'd0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("dat_data", 32'(dout[2]), 32'h5A);
    chk("dat_ncmd", 32'(ncmd[2]), 32'd1);
    chk("nocredit_idle_data", 32'(dout[0]), 32'd0);
    step(1'b0, 8'hFF, 1'b1, 1'b0);
    chk("idle_data", 32'(dout[2]), 32'd0);

    // Bring dut0 to 3 credits, then send and return together.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("refill_to_3", 32'(cred[0]), 32'd3);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("simul_credits", 32'(cred[0]), 32'd3);
    chk("simul_valid", 32'(val[0]), 32'd1);
    chk("simul_data", 32'(dout[0]), 32'h77);

    // Fill dut0 to the cap, then one extra return overflows.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("full_credits", 32'(cred[0]), 32'd8);
    chk("full_no_ovf", 32'(ovf[0]), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_credits", 32'(cred[0]), 32'd8);
    chk("ovf_flag", 32'(ovf[0]), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic tnext;
      tnext = token_i;
      if ($urandom_range(0, 2) == 0) tnext = ~token_i;
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), tnext);
    end
    chk("ovf_sticky", 32'(ovf[0]), 32'd1);

    // Reset, spend six credits, then reset asynchronously mid-cycle.
    reset_i = 1'b1;
    token_i = 1'b0;
    v_i = 1'b0;
    model_reset();
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    chk("pre_arst_credits", 32'(cred[0]), 32'd2);
    chk("pre_arst_valid", 32'(val[0]), 32'd1);
    chk("pre_arst_ncmd", 32'(ncmd[0]), 32'd0);
    #3 reset_i = 1'b1;
    #1;
    chk("arst_valid", 32'(val[0]), 32'd0);
    chk("arst_ncmd", 32'(ncmd[0]), 32'd1);
    chk("arst_data", 32'(dout[0]), 32'd0);
    v_i = 1'b0;
    model_reset();
    @(negedge clk);
    reset_i = 1'b0;
    chk("post_arst_credits", 32'(cred[0]), 32'd8);
    chk("post_arst_overflow", 32'(ovf[0]), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
